ifetch: RTL and testbench

- Instruction fetch unit that produces the instruction word consumed by the decode/control stage.
- Owns the architectural PC and issues word reads to instruction memory over a valid/ready request channel, with a separate response channel.
- Holds each fetched word stable with its PC until the consumer accepts it, and handles redirects (jump/branch) and fetch faults.
- While no fetched word is valid, drives a canonical NOP so decode sees a harmless instruction.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch.sv | 125 ++++++++++++
 tb/tb_ifetch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch unit: NOP encoding, FSM states and PC step.
package ifetch_pkg;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } ifetch_state_t;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues one word read at a time, holds the fetched
// word for decode, and handles redirects and sticky fetch faults.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fault_o
);

    ifetch_state_t r_state;
    logic [31:0]   r_pc;
    logic          r_kill;
    logic          r_instr_valid;
    logic [31:0]   r_instr_data;
    logic [31:0]   r_instr_pc;

    logic w_redir_bad;

    assign w_redir_bad = (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= ST_RESET;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr_data  <= NOP;
            r_instr_pc    <= RESET_PC;
        end else begin
            case (r_state)
                ST_RESET: r_state <= ST_REQ;

                ST_REQ: begin
                    if (redirect_i) begin
                        if (w_redir_bad) begin
                            r_state <= ST_FAULT;
                        end else begin
                            r_pc <= redirect_pc_i;
                            // Request already accepted at the old PC: its response must be dropped.
                            if (imem_req_ready_i) begin
                                r_kill  <= 1'b1;
                                r_state <= ST_WAIT;
                            end
                        end
                    end else if (imem_req_ready_i) begin
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (redirect_i) begin
                        if (w_redir_bad) begin
                            r_kill  <= 1'b0;
                            r_state <= ST_FAULT;
                        end else if (imem_rsp_valid_i) begin
                            r_pc    <= redirect_pc_i;
                            r_kill  <= 1'b0;
                            r_state <= ST_REQ;
                        end else begin
                            r_pc   <= redirect_pc_i;
                            r_kill <= 1'b1;
                        end
                    end else if (imem_rsp_valid_i) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= ST_REQ;
                        end else if (imem_rsp_err_i) begin
                            r_state <= ST_FAULT;
                        end else begin
                            r_instr_valid <= 1'b1;
                            r_instr_data  <= imem_rsp_data_i;
                            r_instr_pc    <= r_pc;
                            r_state       <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (redirect_i) begin
                        r_instr_valid <= 1'b0;
                        r_instr_data  <= NOP;
                        if (w_redir_bad) begin
                            r_state <= ST_FAULT;
                        end else begin
                            r_pc    <= redirect_pc_i;
                            r_state <= ST_REQ;
                        end
                    end else if (instr_ready_i) begin
                        r_instr_valid <= 1'b0;
                        r_instr_data  <= NOP;
                        r_pc          <= r_pc + PC_INC;
                        r_state       <= ST_REQ;
                    end
                end

                ST_FAULT: r_state <= ST_FAULT;

                default: r_state <= ST_FAULT;
            endcase
        end
    end

    assign imem_req_valid_o = (r_state == ST_REQ);
    assign imem_req_addr_o  = r_pc;
    assign instr_valid_o    = r_instr_valid;
    assign instr_data_o     = r_instr_data;
    assign instr_pc_o       = r_instr_pc;
    assign fault_o          = (r_state == ST_FAULT);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: bench drives the memory and consumer, checks against hand-computed values.
module tb_ifetch;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        req_valid, instr_valid, fault;
    logic [31:0] req_addr, instr_data, instr_pc;
    logic        req_valid2, instr_valid2, fault2;
    logic [31:0] req_addr2, instr_data2, instr_pc2;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;

    always #5 clk_i = ~clk_i;

    ifetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(req_addr), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
        .instr_valid_o(instr_valid), .instr_data_o(instr_data), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .fault_o(fault)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .imem_req_valid_o(req_valid2), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(req_addr2), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
        .instr_valid_o(instr_valid2), .instr_data_o(instr_data2), .instr_pc_o(instr_pc2),
        .instr_ready_i(instr_ready_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .fault_o(fault2)
    );

    always @(posedge clk_i) begin
        if (req_valid && imem_req_ready_i) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rstn_i = 1'b0; imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = 32'h0; imem_rsp_err_i = 1'b0; instr_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        tick(); tick();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr_data", instr_data, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fault", {31'd0, fault}, 32'd0);

        // 1: basic fetch with always-ready memory and 1-cycle response
        rstn_i = 1'b1; imem_req_ready_i = 1'b1;
        tick();
        chk("t1_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t1_req_addr", req_addr, 32'h0);
        tick();
        chk("t1_wait_no_req", {31'd0, req_valid}, 32'd0);
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0010_0093;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("t1_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr_data", instr_data, 32'h0010_0093);
        chk("t1_instr_pc", instr_pc, 32'h0);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        chk("t1_consumed_valid", {31'd0, instr_valid}, 32'd0);
        chk("t1_consumed_nop", instr_data, 32'h0000_0013);
        chk("t1_next_addr", req_addr, 32'h4);

        // 2: memory stalls the request for 3 cycles
        imem_req_ready_i = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall_valid", {31'd0, req_valid}, 32'd1);
            chk("t2_stall_addr", req_addr, 32'h4);
        end
        imem_req_ready_i = 1'b1;
        tick();
        chk("t2_accepted_wait", {31'd0, req_valid}, 32'd0);
        chk("t2_accept_count", acc_cnt, 32'd1);
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0113;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("t2_instr_pc", instr_pc, 32'h4);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        chk("t2_next_addr", req_addr, 32'h8);

        // 4: redirect beats simultaneous consume in HOLD at pc 8
        tick();
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0193;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("t4_hold_pc", instr_pc, 32'h8);
        redirect_i = 1'b1; redirect_pc_i = 32'h200; instr_ready_i = 1'b1;
        tick();
        redirect_i = 1'b0; instr_ready_i = 1'b0;
        chk("t4_redirect_addr", req_addr, 32'h200);
        chk("t4_instr_valid", {31'd0, instr_valid}, 32'd0);

        // 3: redirect while waiting; stale response must be dropped
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        chk("t3_wait_no_req", {31'd0, req_valid}, 32'd0);
        tick();
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("t3_discard_valid", {31'd0, instr_valid}, 32'd0);
        chk("t3_discard_nop", instr_data, 32'h0000_0013);
        chk("t3_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t3_req_addr", req_addr, 32'h100);
        tick();
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0020_0113;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("t3_new_data", instr_data, 32'h0020_0113);
        chk("t3_new_pc", instr_pc, 32'h100);

        // 5a: misaligned redirect from HOLD -> sticky fault
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
        tick();
        redirect_pc_i = 32'h300;
        chk("t5a_fault", {31'd0, fault}, 32'd1);
        chk("t5a_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5a_instr_nop", instr_data, 32'h0000_0013);
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5a_no_req", {31'd0, req_valid}, 32'd0);
            chk("t5a_fault_sticky", {31'd0, fault}, 32'd1);
        end
        redirect_i = 1'b0;
        chk("t5a_no_accepts", acc_cnt, 32'd0);
        rstn_i = 1'b0;
        #1;
        chk("t5a_async_clear", {31'd0, fault}, 32'd0);
        chk("t5a_async_addr", req_addr, 32'h0);
        tick();
        rstn_i = 1'b1;

        // 5b: error response -> fault
        tick();
        chk("t5b_req_addr", req_addr, 32'h0);
        tick();
        imem_rsp_valid_i = 1'b1; imem_rsp_err_i = 1'b1; imem_rsp_data_i = 32'h0;
        tick();
        imem_rsp_valid_i = 1'b0; imem_rsp_err_i = 1'b0;
        chk("t5b_fault", {31'd0, fault}, 32'd1);
        chk("t5b_instr_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("t5b_no_req", {31'd0, req_valid}, 32'd0);

        // 6: PC wrap at top of address space
        rstn_i = 1'b0;
        tick();
        chk("t6_rst_addr", req_addr2, 32'hFFFF_FFFC);
        rstn_i = 1'b1;
        tick();
        chk("t6_req_addr", req_addr2, 32'hFFFF_FFFC);
        tick();
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0013;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("t6_hold_pc", instr_pc2, 32'hFFFF_FFFC);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        chk("t6_wrap_addr", req_addr2, 32'h0);
        chk("t6_wrap_valid", {31'd0, req_valid2}, 32'd1);
        chk("t6_no_fault", {31'd0, fault2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
